sensor_agua: RTL and testbench

SENSOR_AGUA -- requirements
Module: sensor_agua

---
 rtl/sensor_agua.sv | 188 ++++++++++++++++++
 tb/tb_sensor_agua.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_agua.sv
// sensor_agua: ultrasonic water-level sensor controller for the coffee machine.
// Sends a trigger pulse, times the echo-high interval in centimetres, and
// judges whether the water surface is close enough to the sensor
// (distance <= LIMIAR_CM) to mean there is enough water.
// Optional feature: define SENSOR_AGUA_FILTRO_EN to add a 4-sample echo
// glitch filter after the synchronizer.
//
// Handshake: medir is a one-cycle request and is accepted only in IDLE
// (ignored elsewhere). The result is reported by the levels pronto
// (with suficiente/distancia) or timeout. These two are never high
// together, and they hold until the next accepted medir or zera.
// zera aborts from any state and takes priority over medir.
`timescale 1ns/1ps
module sensor_agua #(
  parameter int TRIG_CICLOS    = 500,
  parameter int CICLOS_CM      = 2941,
  parameter int LIMIAR_CM      = 10,
  parameter int TIMEOUT_CICLOS = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic       medir,
  input  logic       echo,
  output logic       trigger,
  output logic       pronto,
  output logic       suficiente,
  output logic       timeout,
  output logic [8:0] distancia,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    TRIGGER     = 3'd1,
    ESPERA_ECHO = 3'd2,
    MEDE        = 3'd3,
    FIM         = 3'd4,
    ERRO        = 3'd5
  } estado_t;

  // The cm counter also times the trigger pulse, so it must hold either range.
  localparam int CM_MAX = (TRIG_CICLOS > CICLOS_CM) ? TRIG_CICLOS : CICLOS_CM;
  localparam int CM_W   = $clog2(CM_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CICLOS + 1);

  localparam logic [CM_W-1:0]  TRIG_FIM = CM_W'(TRIG_CICLOS - 1);
  localparam logic [CM_W-1:0]  CM_FIM   = CM_W'(CICLOS_CM - 1);
  localparam logic [TMO_W-1:0] TMO_FIM  = TMO_W'(TIMEOUT_CICLOS - 1);

  estado_t          estado_q;
  logic [CM_W-1:0]  cm_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             sync1_q, sync2_q;
  logic             echo_s;
  logic             echo_prev_q;
  logic             tmo_fim;
  logic             medindo;

  // Two-flop synchronizer for the asynchronous echo pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

`ifdef SENSOR_AGUA_FILTRO_EN
  logic [2:0] hist_q;
  logic       filt_q;
  logic       estavel;

  // The last three synchronized samples plus the current one must agree
  // before echo_s follows. That gives 3 clocks of added delay per edge.
  assign estavel = (hist_q == {3{sync2_q}});
  assign echo_s  = estavel ? sync2_q : filt_q;

  // Sample history and the last accepted filtered value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= 3'b000;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[1:0], sync2_q};
      if (estavel) filt_q <= sync2_q;
    end
  end
`else
  assign echo_s = sync2_q;
`endif

  // Previous echo_s, so ESPERA_ECHO reacts only to a genuine 0->1 edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) echo_prev_q <= 1'b0;
    else        echo_prev_q <= echo_s;
  end

  assign medindo   = (estado_q == TRIGGER) || (estado_q == ESPERA_ECHO) ||
                     (estado_q == MEDE);
  assign tmo_fim   = (tmo_cnt_q == TMO_FIM);
  assign db_estado = estado_q;

  // Measurement FSM with registered outputs and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= IDLE;
      trigger    <= 1'b0;
      pronto     <= 1'b0;
      suficiente <= 1'b0;
      timeout    <= 1'b0;
      distancia  <= 9'd0;
      cm_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
    end else if (zera) begin
      estado_q   <= IDLE;
      trigger    <= 1'b0;
      pronto     <= 1'b0;
      suficiente <= 1'b0;
      timeout    <= 1'b0;
      distancia  <= 9'd0;
      cm_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
    end else if (medindo && tmo_fim) begin
      // Echo never finished in time: report the failure and give up.
      estado_q <= ERRO;
      trigger  <= 1'b0;
      pronto   <= 1'b0;
      timeout  <= 1'b1;
    end else begin
      if (medindo) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      case (estado_q)
        IDLE: begin
          if (medir) begin
            estado_q   <= TRIGGER;
            trigger    <= 1'b1;
            pronto     <= 1'b0;
            suficiente <= 1'b0;
            timeout    <= 1'b0;
            distancia  <= 9'd0;
            cm_cnt_q   <= '0;
            tmo_cnt_q  <= '0;
          end
        end
        TRIGGER: begin
          if (cm_cnt_q == TRIG_FIM) begin
            estado_q <= ESPERA_ECHO;
            trigger  <= 1'b0;
            cm_cnt_q <= '0;
          end else begin
            cm_cnt_q <= cm_cnt_q + CM_W'(1);
          end
        end
        ESPERA_ECHO: begin
          // The detect cycle already has echo high, so it counts as the first.
          if (echo_s && !echo_prev_q) begin
            estado_q <= MEDE;
            cm_cnt_q <= CM_W'(1);
          end
        end
        MEDE: begin
          if (!echo_s) begin
            estado_q <= FIM;
          end else if (cm_cnt_q == CM_FIM) begin
            cm_cnt_q <= '0;
            if (distancia != 9'd511) distancia <= distancia + 9'd1;
          end else begin
            cm_cnt_q <= cm_cnt_q + CM_W'(1);
          end
        end
        FIM: begin
          estado_q   <= IDLE;
          pronto     <= 1'b1;
          suficiente <= (int'(distancia) <= LIMIAR_CM);
        end
        ERRO: begin
          estado_q <= IDLE;
        end
        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_agua.sv
// Bench for sensor_agua. It uses scaled-down timing parameters so that
// saturation and timeout fit in a short run. The model computes each result
// from the echo width: distance = width / CICLOS_CM saturated at 511, and
// sufficient = distance <= LIMIAR_CM.
`timescale 1ns/1ps
module tb_sensor_agua;

  localparam int TRIG = 5;
  localparam int CCM  = 3;
  localparam int LIM  = 10;
  localparam int TMO  = 2000;
`ifdef SENSOR_AGUA_FILTRO_EN
  localparam int       LAT    = 7;
  localparam bit       FILTRO = 1'b1;
`else
  localparam int       LAT    = 4;
  localparam bit       FILTRO = 1'b0;
`endif
  localparam int W = 12;  // {pronto, timeout, suficiente, distancia}

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zera  = 1'b0;
  logic       medir = 1'b0;
  logic       echo  = 1'b0;
  logic       trigger, pronto, suficiente, timeout;
  logic [8:0] distancia;
  logic [2:0] db_estado;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_mon;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         prev_p = 1'b0;
  logic         prev_t = 1'b0;
  logic         viu_mede = 1'b0;

  sensor_agua #(
    .TRIG_CICLOS   (TRIG),
    .CICLOS_CM     (CCM),
    .LIMIAR_CM     (LIM),
    .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .zera      (zera),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .pronto    (pronto),
    .suficiente(suficiente),
    .timeout   (timeout),
    .distancia (distancia),
    .db_estado (db_estado)
  );

  // Clock and reset.
  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nome, got, got, exp, exp);
    end
  endtask

  function automatic logic [W-1:0] modelo_medida(input int largura);
    int d;
    d = largura / CCM;
    if (d > 511) d = 511;
    return {1'b1, 1'b0, (d <= LIM), 9'(d)};
  endfunction

  function automatic logic [W-1:0] modelo_timeout();
    return {1'b1 ^ 1'b1, 1'b1, 1'b0, 9'd0};
  endfunction

  // Monitor: on each new result, pop the expectation and compare.
  always @(negedge clock) begin
    if ((pronto && !prev_p) || (timeout && !prev_t)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resultado_inesperado: got 0x%0h expected none",
                 {pronto, timeout, suficiente, distancia});
      end else begin
        e_mon = exp_q.pop_front();
        check("resultado", 32'({pronto, timeout, suficiente, distancia}), 32'(e_mon));
      end
    end
    prev_p = pronto;
    prev_t = timeout;
    if (db_estado == 3'd3) viu_mede = 1'b1;
  end

  // Driver tasks.
  task automatic inicia_medida();
    @(negedge clock);
    medir = 1'b1;
    @(posedge clock);
    #1;
    medir = 1'b0;
  endtask

  task automatic espera_trigger();
    int n = 0;
    while (trigger && n < TRIG + 20) begin
      n++;
      @(posedge clock);
      #1;
    end
    check("largura_trigger", 32'(n), 32'(TRIG));
  endtask

  task automatic espera_fim();
    int n = 0;
    while (!(pronto || timeout) && n < TMO + 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!(pronto || timeout)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL espera_fim: got no result after %0d cycles expected pronto or timeout", n);
    end
    @(negedge clock);
  endtask

  task automatic mede(input int largura, input int atraso);
    int n = 0;
    exp_q.push_back(modelo_medida(largura));
    inicia_medida();
    espera_trigger();
    repeat (atraso) @(negedge clock);
    echo = 1'b1;
    repeat (largura) @(negedge clock);
    echo = 1'b0;
    while (!pronto && n < LAT + 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("latencia_pronto", 32'(n), 32'(LAT));
    @(negedge clock);
  endtask

  task automatic mede_sem_echo();
    int n = 0;
    exp_q.push_back(modelo_timeout());
    inicia_medida();
    while (!timeout && n < TMO + 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("instante_timeout", 32'(n), 32'(TMO));
    @(negedge clock);
  endtask

  task automatic aborta_em_mede();
    int n = 0;
    inicia_medida();
    espera_trigger();
    @(negedge clock);
    echo = 1'b1;
    while (db_estado != 3'd3 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("entrou_mede", 32'(db_estado), 32'd3);
    repeat (3) @(negedge clock);
    zera = 1'b1;
    @(posedge clock);
    #1;
    check("zera_saidas", 32'({db_estado, trigger, pronto, suficiente, timeout, distancia}), 32'd0);
    @(negedge clock);
    zera = 1'b0;
    echo = 1'b0;
    repeat (5) @(negedge clock);
    zera  = 1'b1;
    medir = 1'b1;
    @(posedge clock);
    #1;
    check("zera_vence_medir", 32'({db_estado, trigger}), 32'd0);
    @(negedge clock);
    zera  = 1'b0;
    medir = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic glitch();
    if (FILTRO) exp_q.push_back(modelo_timeout());
    else        exp_q.push_back(modelo_medida(2));
    inicia_medida();
    espera_trigger();
    @(negedge clock);
    viu_mede = 1'b0;
    echo = 1'b1;
    repeat (2) @(negedge clock);
    echo = 1'b0;
    espera_fim();
    check("glitch_entra_mede", 32'(viu_mede), 32'(!FILTRO));
  endtask

  // Stimulus sequence and final report.
  initial begin
    int larguras[4] = '{30, 29, 32, 33};
    repeat (3) @(negedge clock);
    check("reset_saidas",
          32'({db_estado, trigger, pronto, suficiente, timeout, distancia}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("pos_reset_idle", 32'({db_estado, trigger}), 32'd0);

    foreach (larguras[i]) mede(larguras[i], 3);
    for (int k = 0; k < 6; k++) mede(int'($urandom_range(4, 70)), int'($urandom_range(1, 8)));

    mede_sem_echo();
    aborta_em_mede();
    mede(45, 2);
    mede(1700, 4);
    glitch();

    repeat (5) @(negedge clock);
    check("fila_vazia", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL limite_tempo: got no end expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule
